// File: rtl/run_host.sv
// run_host: sequences preload, core request, bounded wait and read-back of a run.
module run_host #(
    parameter int LOAD_BASE = 0,
    parameter int LOAD_N    = 64,
    parameter int READ_BASE = 64,
    parameter int READ_N    = 32,
    parameter int TMO       = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    output logic       ld_ready,
    output logic       mem_wr_en,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wr_dat,
    input  logic [7:0] mem_rd_dat,
    output logic       req,
    input  logic       done,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    input  logic       rd_ready,
    output logic       busy,
    output logic       timeout
);
    typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT, READ, ERR} state_t;
    localparam logic [7:0]  LB = 8'(LOAD_BASE);
    localparam logic [7:0]  RB = 8'(READ_BASE);
    localparam logic [8:0]  LL = 9'(LOAD_N - 1);
    localparam logic [8:0]  RL = 9'(READ_N - 1);
    localparam logic [15:0] TL = 16'(TMO - 1);
    state_t      r_state, w_next, w_st;
    logic [8:0]  r_cnt;
    logic [15:0] r_wcnt;
    logic        r_timeout;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_wcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wcnt  <= (r_state == WAIT) ? r_wcnt + 16'd1 : '0;
            if (r_state == IDLE && start) begin
                r_cnt     <= '0;
                r_timeout <= 1'b0;
            end else if (r_state == WAIT && w_next == READ)
                r_cnt <= '0;
            else if ((r_state == LOAD && ld_valid) || (r_state == READ && rd_ready))
                r_cnt <= r_cnt + 9'd1;
            if (r_state == WAIT && w_next == ERR)
                r_timeout <= 1'b1;
        end
    end
    // The first WAIT cycle ignores done, since it may still be high from the previous run.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start) w_next = LOAD;
            LOAD: if (ld_valid && r_cnt == LL) w_next = REQ;
            REQ:  w_next = WAIT;
            WAIT: if (done && r_wcnt != '0) w_next = READ;
                  else if (r_wcnt == TL) w_next = ERR;
            READ: if (rd_ready && r_cnt == RL) w_next = IDLE;
            ERR:  if (!start) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    // Reset masks the outputs immediately so an abandoned run cannot write on the reset edge.
    always_comb begin
        w_st       = reset ? IDLE : r_state;
        ld_ready   = w_st == LOAD;
        mem_wr_en  = ld_ready && ld_valid;
        mem_wr_dat = ld_ready ? ld_data : 8'h00;
        req        = w_st == REQ;
        rd_valid   = w_st == READ;
        rd_data    = rd_valid ? mem_rd_dat : 8'h00;
        mem_addr   = ld_ready ? LB + r_cnt[7:0] : rd_valid ? RB + r_cnt[7:0] : 8'h00;
        busy       = w_st != IDLE;
        timeout    = r_timeout && !reset;
    end
endmodule

// File: tb/tb_run_host.sv
// tb_run_host: directed vector table plus hand-written sequences for run_host.
module tb_run_host;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       a_start, a_ldv, a_done, a_rdr, a_ldr, a_we, a_req, a_rv, a_busy, a_to;
    logic [7:0] a_ldd, a_addr, a_wd, a_mrd, a_rd;
    logic       b_start, b_ldv, b_done, b_rdr, b_ldr, b_we, b_req, b_rv, b_busy, b_to;
    logic [7:0] b_ldd, b_addr, b_wd, b_mrd, b_rd;

    logic [7:0]  mem_a [256];
    logic [15:0] log_a [$];
    logic [15:0] log_b [$];
    assign a_mrd = mem_a[a_addr];
    assign b_mrd = 8'h3C;

    run_host #(.LOAD_BASE(0), .LOAD_N(4), .READ_BASE(64), .READ_N(2), .TMO(4096)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .ld_valid(a_ldv), .ld_data(a_ldd),
        .ld_ready(a_ldr), .mem_wr_en(a_we), .mem_addr(a_addr), .mem_wr_dat(a_wd),
        .mem_rd_dat(a_mrd), .req(a_req), .done(a_done), .rd_valid(a_rv), .rd_data(a_rd),
        .rd_ready(a_rdr), .busy(a_busy), .timeout(a_to));

    run_host #(.LOAD_BASE(254), .LOAD_N(256), .READ_BASE(64), .READ_N(1), .TMO(8)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .ld_valid(b_ldv), .ld_data(b_ldd),
        .ld_ready(b_ldr), .mem_wr_en(b_we), .mem_addr(b_addr), .mem_wr_dat(b_wd),
        .mem_rd_dat(b_mrd), .req(b_req), .done(b_done), .rd_valid(b_rv), .rd_data(b_rd),
        .rd_ready(b_rdr), .busy(b_busy), .timeout(b_to));

    always @(posedge clk) begin
        if (a_we) begin
            mem_a[a_addr] <= a_wd;
            log_a.push_back({a_addr, a_wd});
        end
        if (b_we) log_b.push_back({b_addr, b_wd});
    end

    int nchk = 0;
    int nerr = 0;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    typedef struct {
        int         n;
        logic [3:0] i;
        logic [7:0] d;
        logic [4:0] x;
        logic [7:0] ad;
        logic [7:0] rd;
    } vec_t;
    vec_t tbl [14];

    task automatic load_b;
        b_ldv = 1'b1;
        for (int i = 0; i < 256; i++) begin
            b_ldd = 8'(i);
            @(negedge clk);
        end
        b_ldv = 1'b0;
    endtask

    initial begin
        {a_start, a_ldv, a_done, a_rdr, a_ldd} = '0;
        {b_start, b_ldv, b_done, b_rdr, b_ldd} = '0;
        mem_a[64] = 8'hA5;
        mem_a[65] = 8'h5A;
        tbl = '{
            '{1,  4'b1000, 8'h00, 5'b00000, 8'h00, 8'h00},
            '{1,  4'b0100, 8'h11, 5'b11001, 8'h00, 8'h00},
            '{1,  4'b1000, 8'h99, 5'b10001, 8'h01, 8'h00},
            '{1,  4'b0100, 8'h22, 5'b11001, 8'h01, 8'h00},
            '{1,  4'b0000, 8'h99, 5'b10001, 8'h02, 8'h00},
            '{1,  4'b0100, 8'h33, 5'b11001, 8'h02, 8'h00},
            '{1,  4'b0100, 8'h44, 5'b11001, 8'h03, 8'h00},
            '{1,  4'b0000, 8'h00, 5'b00101, 8'h00, 8'h00},
            '{10, 4'b0000, 8'h00, 5'b00001, 8'h00, 8'h00},
            '{1,  4'b0010, 8'h00, 5'b00001, 8'h00, 8'h00},
            '{5,  4'b0000, 8'h00, 5'b00011, 8'h40, 8'hA5},
            '{1,  4'b0001, 8'h00, 5'b00011, 8'h40, 8'hA5},
            '{1,  4'b0001, 8'h00, 5'b00011, 8'h41, 8'h5A},
            '{1,  4'b0000, 8'h00, 5'b00000, 8'h00, 8'h00}
        };
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset a", {a_ldr, a_we, a_req, a_rv, a_busy, a_to, a_addr, a_wd}, '0);
        chk("reset b", {b_ldr, b_we, b_req, b_rv, b_busy, b_to, b_addr, b_wd}, '0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 14; k++)
            for (int r = 0; r < tbl[k].n; r++) begin
                {a_start, a_ldv, a_done, a_rdr} = tbl[k].i;
                a_ldd = tbl[k].d;
                #1;
                chk($sformatf("vec %0d.%0d", k, r),
                    {a_ldr, a_we, a_req, a_rv, a_busy, a_addr, a_wd, a_rd},
                    {tbl[k].x, tbl[k].ad, tbl[k].x[4] ? tbl[k].d : 8'h00, tbl[k].rd});
                @(negedge clk);
            end
        chk("nominal wr count", log_a.size(), 4);
        chk("nominal wr 0", log_a[0], 16'h0011);
        chk("nominal wr 1", log_a[1], 16'h0122);
        chk("nominal wr 2", log_a[2], 16'h0233);
        chk("nominal wr 3", log_a[3], 16'h0344);

        reset = 1'b1;
        a_done = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_ldv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_ldd = 8'(i + 1);
            @(negedge clk);
        end
        a_ldv = 1'b0;
        #1 chk("stale req", {a_req, a_busy}, 2'b11);
        @(negedge clk);
        #1 chk("stale wait0", {a_rv, a_busy}, 2'b01);
        @(negedge clk);
        #1 chk("stale wait1", {a_rv, a_busy}, 2'b01);
        @(negedge clk);
        a_rdr = 1'b1;
        #1 chk("stale read0", {a_rv, a_rd}, {1'b1, 8'hA5});
        @(negedge clk);
        #1 chk("stale read1", {a_rv, a_rd}, {1'b1, 8'h5A});
        @(negedge clk);
        #1 chk("stale idle", {a_rv, a_busy}, 2'b00);
        a_done = 1'b0;
        a_rdr = 1'b0;

        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_ldv = 1'b1;
        a_ldd = 8'h77;
        @(negedge clk);
        a_ldd = 8'h88;
        reset = 1'b1;
        #1 chk("rst load during", {a_ldr, a_we, a_busy, a_addr, a_wd}, '0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst load after", {a_ldr, a_we, a_busy, a_addr, a_wd}, '0);
        @(negedge clk);
        a_ldv = 1'b0;
        chk("rst load wr count", log_a.size(), 9);
        chk("rst load last wr", log_a[8], 16'h0077);

        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_ldv = 1'b1;
        repeat (4) @(negedge clk);
        a_ldv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a_done = 1'b1;
        @(negedge clk);
        a_done = 1'b0;
        #1 chk("pre rst read", {a_rv, a_busy, a_addr}, {2'b11, 8'h40});
        @(negedge clk);
        reset = 1'b1;
        #1 chk("rst read during", {a_rv, a_busy, a_addr, a_rd}, '0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst read after", {a_rv, a_busy, a_addr, a_rd}, '0);
        @(negedge clk);

        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        load_b();
        #1 chk("wrap term", {b_req, b_ldr}, 2'b10);
        chk("wrap wr count", log_b.size(), 256);
        chk("wrap wr 0", log_b[0], 16'hFE00);
        chk("wrap wr 1", log_b[1], 16'hFF01);
        chk("wrap wr 2", log_b[2], 16'h0002);
        chk("wrap wr 3", log_b[3], 16'h0103);
        chk("wrap wr 255", log_b[255], 16'hFDFF);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 chk($sformatf("tmo wait %0d", i), {b_to, b_busy, b_rv}, 3'b010);
            @(negedge clk);
        end
        b_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("err held %0d", i), {b_to, b_busy}, 2'b11);
            @(negedge clk);
        end
        b_start = 1'b0;
        #1 chk("err release", {b_to, b_busy}, 2'b11);
        @(negedge clk);
        #1 chk("err idle sticky", {b_to, b_busy}, 2'b10);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        #1 chk("restart clears", {b_to, b_busy, b_ldr}, 3'b011);
        load_b();
        @(negedge clk);
        repeat (7) @(negedge clk);
        b_done = 1'b1;
        #1 chk("tie wait", {b_to, b_rv}, 2'b00);
        @(negedge clk);
        b_done = 1'b0;
        b_rdr = 1'b1;
        #1 chk("tie done wins", {b_to, b_rv, b_addr, b_rd}, {2'b01, 8'h40, 8'h3C});
        @(negedge clk);
        b_rdr = 1'b0;
        #1 chk("tie idle", {b_to, b_busy}, 2'b00);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
